memory_game_sequencer: RTL

Central game-flow controller for the memory game. It generates a growing random pattern of four symbols and plays it out on LEDs, timed by the game tick from the clock divider. It then accepts player button presses and checks them against the pattern, ending each round in WIN or LOSE. It sits between the clock divider (tick strobe), the debounced button front end, and the LED and score display logic.

---
 rtl/memory_game_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/memory_game_sequencer.sv
// Game-flow controller for the memory game: grows a random symbol pattern,
// plays it out on the LEDs at tick rate, then checks the player's repeat.
module memory_game_sequencer #(
  parameter int         MAX_LEN       = 16,
  parameter int         LVL_W         = 5,
  parameter int         SHOW_TICKS    = 2,
  parameter int         GAP_TICKS     = 1,
  parameter int         TIMEOUT_TICKS = 10,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             tick,
  input  logic             start,
  input  logic [3:0]       btn,
  output logic [3:0]       led,
  output logic [LVL_W-1:0] level,
  output logic [2:0]       state,
  output logic             win,
  output logic             lose,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPEND   = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SG_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int CNT_W  = (SG_MAX > 1) ? $clog2(SG_MAX) : 1;
  localparam int TO_W   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [LVL_W-1:0] MAX_LVL   = LVL_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]    timeout_cnt_q, timeout_cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               win_q, lose_q, busy_q;
  logic               pat_we;
  logic [1:0]         pattern_q [MAX_LEN];

  logic [1:0]         cur_sym;
  logic               btn_ok;
  logic               last_idx;

  // Galois LFSR, right shift, taps 8'hB8; free-running so the pattern
  // depends on when the player presses start.
  assign lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  assign cur_sym  = pattern_q[idx_q[IDX_W-1:0]];
  assign btn_ok   = (btn == (4'b0001 << cur_sym));
  assign last_idx = (idx_q == level_q - LVL_W'(1));

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    idx_d         = idx_q;
    tick_cnt_d    = tick_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    pat_we        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_APPEND;
      end
      S_APPEND: begin
        pat_we     = 1'b1;
        level_d    = level_q + LVL_W'(1);
        idx_d      = '0;
        tick_cnt_d = '0;
        state_d    = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick) begin
          if (tick_cnt_q == SHOW_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_SHOW_OFF;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      S_SHOW_OFF: begin
        if (tick) begin
          if (tick_cnt_q == GAP_LAST) begin
            tick_cnt_d = '0;
            if (last_idx) begin
              idx_d         = '0;
              timeout_cnt_d = '0;
              state_d       = S_INPUT;
            end else begin
              idx_d   = idx_q + LVL_W'(1);
              state_d = S_SHOW_ON;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      S_INPUT: begin
        // A press in the same cycle as a tick wins; the tick is dropped.
        if (btn != 4'b0000) begin
          if (btn_ok) begin
            timeout_cnt_d = '0;
            if (!last_idx)               idx_d   = idx_q + LVL_W'(1);
            else if (level_q == MAX_LVL) state_d = S_WIN;
            else                         state_d = S_APPEND;
          end else begin
            state_d = S_LOSE;
          end
        end else if (tick) begin
          if (timeout_cnt_q == TO_LAST) state_d = S_LOSE;
          else timeout_cnt_d = timeout_cnt_q + TO_W'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          level_d = '0;
          state_d = S_APPEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      level_q       <= '0;
      idx_q         <= '0;
      tick_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      lfsr_q        <= LFSR_SEED;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      idx_q         <= idx_d;
      tick_cnt_q    <= tick_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      lfsr_q        <= lfsr_d;
      win_q         <= (state_d == S_WIN);
      lose_q        <= (state_d == S_LOSE);
      busy_q        <= (state_d == S_APPEND) || (state_d == S_SHOW_ON) ||
                       (state_d == S_SHOW_OFF) || (state_d == S_INPUT);
    end
  end

  // Pattern contents need no reset: every entry is written before it is read.
  always_ff @(posedge clock) begin
    if (pat_we) pattern_q[level_q[IDX_W-1:0]] <= lfsr_q[1:0];
  end

  always_comb begin
    led = 4'b0000;
    case (state_q)
      S_SHOW_ON: led = 4'b0001 << cur_sym;
      S_INPUT:   led = btn;
      S_WIN:     led = 4'b1111;
      default:   led = 4'b0000;
    endcase
  end

  assign state = state_q;
  assign level = level_q;
  assign win   = win_q;
  assign lose  = lose_q;
  assign busy  = busy_q;

endmodule
